// File: rtl/dff_bank_arbiter_pkg.sv
// dff_arb_pkg: shared types and constants for the dff_bank_arbiter block.
//   arb_state_e : arbiter FSM state (IDLE, GRANT)
//   NREQ_DFLT   : default requester count
//   OWNER_W     : owner index width for the default requester count
package dff_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int unsigned NREQ_DFLT = 4;
    localparam int unsigned OWNER_W   = $clog2(NREQ_DFLT);

endpackage

// File: rtl/dff_bank_arbiter_if.sv
// dff_bank_arbiter_if: request/write bus between requesting logic and the
// shared register bank arbiter.
//   req   : per-requester request, held high while the bank is wanted
//   wdata : per-requester write data, slice i = [i*WIDTH +: WIDTH]
//   grant : one-hot registered grant
//   busy  : high while any grant is active
//   owner : index of current or last grantee
//   q     : register bank contents
//   q_bar : bitwise complement of q
// Modports: master = requesting side, slave = arbiter.
interface dff_bank_arbiter_if #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned OW = $clog2(NREQ);

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ-1:0]       grant;
    logic                  busy;
    logic [OW-1:0]         owner;
    logic [WIDTH-1:0]      q;
    logic [WIDTH-1:0]      q_bar;

    modport master (
        output req, wdata,
        input  grant, busy, owner, q, q_bar
    );

    modport slave (
        input  req, wdata,
        output grant, busy, owner, q, q_bar
    );

endinterface

// File: rtl/dff_bank_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority picker.
//   req_i   : request vector
//   ptr_i   : index of the last grantee (lowest priority)
//   valid_o : at least one request is set
//   idx_o   : first set request searching ptr_i+1, ptr_i+2, ... modulo NREQ
module rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned OW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [OW-1:0]   ptr_i,
    output logic            valid_o,
    output logic [OW-1:0]   idx_o
);

    logic [OW-1:0] cand;
    logic          found;

    always_comb begin
        found = 1'b0;
        idx_o = '0;
        cand  = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            cand = OW'((32'(ptr_i) + i) % NREQ);
            if (!found && req_i[cand]) begin
                found = 1'b1;
                idx_o = cand;
            end
        end
    end

    assign valid_o = found;

endmodule

// File: rtl/dff_bank_arbiter.sv
// dff_bank_arbiter: round-robin arbiter owning a WIDTH-bit register bank.
// Each grantee may write the bank for up to HOLD_MAX cycles per tenure; every
// tenure is followed by one idle cycle before the next grant.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : dff_bank_arbiter_if slave (req, wdata in; grant, busy, owner, q, q_bar out)
module dff_bank_arbiter
    import dff_arb_pkg::*;
#(
    parameter int unsigned NREQ     = NREQ_DFLT,
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned HOLD_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    dff_bank_arbiter_if.slave   bus
);

    localparam int unsigned OW = $clog2(NREQ);
    localparam int unsigned HW = $clog2(HOLD_MAX + 1);

    arb_state_e       state_q;
    logic [NREQ-1:0]  grant_q;
    logic             busy_q;
    logic [OW-1:0]    owner_q;
    logic [OW-1:0]    ptr_q;
    logic [HW-1:0]    hold_q;
    logic [WIDTH-1:0] bank_q;

    logic             pick_valid;
    logic [OW-1:0]    pick_idx;
    logic             owner_req;
    logic [WIDTH-1:0] owner_wdata;

    rr_pick #(
        .NREQ (NREQ),
        .OW   (OW)
    ) u_pick (
        .req_i   (bus.req),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    assign owner_req   = bus.req[owner_q];
    assign owner_wdata = bus.wdata[32'(owner_q) * WIDTH +: WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
            owner_q <= '0;
            ptr_q   <= OW'(NREQ - 1);
            hold_q  <= '0;
            bank_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        grant_q <= NREQ'(1) << pick_idx;
                        owner_q <= pick_idx;
                        busy_q  <= 1'b1;
                        hold_q  <= '0;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    // Release either when the owner drops its request or after
                    // its last allowed write; the releasing owner becomes ptr so
                    // it has lowest priority at the next arbitration.
                    if (owner_req) begin
                        bank_q <= owner_wdata;
                        hold_q <= hold_q + 1'b1;
                    end
                    if (!owner_req || hold_q == HW'(HOLD_MAX - 1)) begin
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        ptr_q   <= owner_q;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.grant = grant_q;
    assign bus.busy  = busy_q;
    assign bus.owner = owner_q;
    assign bus.q     = bank_q;
    assign bus.q_bar = ~bank_q;

    grant_onehot_a: assert property (@(posedge clk) $onehot0(grant_q));

endmodule
